// File: rtl/jtsdram_pkg.sv
// Shared SDRAM tester constants: default blink-code timings so the tester top
// and the simulation agree on one set of numbers.
package jtsdram_pkg;

  localparam int JTS_BANKS = 4;
  localparam int JTS_ONF   = 8;
  localparam int JTS_OFFF  = 8;
  localparam int JTS_GAPF  = 32;
  localparam int JTS_TW    = 6;

endpackage

// File: rtl/jtsdram_rrpick.sv
// Combinational round-robin picker: first set bit of req scanning last+1,
// last+2, ... modulo BANKS, so the previously picked bank comes last.
module jtsdram_rrpick #(
  parameter int BANKS = 4
) (
  input  logic [BANKS-1:0] req,
  input  logic [2:0]       last,
  output logic [2:0]       idx,
  output logic             any
);

  logic [2:0]       pos [BANKS];
  logic [BANKS-1:0] hit;

  generate
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_rot
      logic [3:0] sum;
      assign sum     = {1'b0, last} + 4'(gi + 1);
      assign pos[gi] = 3'(sum % 4'(BANKS));
      assign hit[gi] = req[pos[gi]];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx = '0;
    for (int i = BANKS - 1; i >= 0; i--) begin
      if (hit[i]) idx = pos[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/jtsdram_ledcode.sv
// Multiplexes per-bank SDRAM error flags onto one LED as blink codes:
// bank k blinks k+1 times then stays dark for a gap; banks rotate round-robin.
module jtsdram_ledcode
  import jtsdram_pkg::*;
#(
  parameter int BANKS = JTS_BANKS,
  parameter int ONF   = JTS_ONF,
  parameter int OFFF  = JTS_OFFF,
  parameter int GAPF  = JTS_GAPF,
  parameter int TW    = JTS_TW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LVBL,
  input  logic [BANKS-1:0] bad,
  output logic             led,
  output logic             busy,
  output logic [2:0]       cur_bank
);

  localparam int BW = $clog2(BANKS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [BW-1:0] blinks_reg, blinks_next;
  logic [2:0]    last_reg, last_next;
  logic [2:0]    bank_reg, bank_next;
  logic          last_lvbl_reg, tick_reg;
  logic          led_reg, busy_reg;

  logic [2:0]    pick_idx;
  logic          pick_any;

  jtsdram_rrpick #(.BANKS(BANKS)) u_pick (
    .req  (bad),
    .last (last_reg),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lvbl_reg <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      last_lvbl_reg <= LVBL;
      tick_reg      <= LVBL & ~last_lvbl_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      timer_reg  <= '0;
      blinks_reg <= '0;
      last_reg   <= 3'(BANKS - 1);
      bank_reg   <= '0;
      led_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      blinks_reg <= blinks_next;
      last_reg   <= last_next;
      bank_reg   <= bank_next;
      led_reg    <= (state_next == ST_ON);
      busy_reg   <= (state_next != ST_IDLE);
    end
  end

  // Every phase reloads its timer on the tick where it reads 1, so it never hits 0.
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    blinks_next = blinks_reg;
    last_next   = last_reg;
    bank_next   = bank_reg;
    if (tick_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            state_next  = ST_ON;
            timer_next  = TW'(ONF);
            blinks_next = BW'(pick_idx) + BW'(1);
            last_next   = pick_idx;
            bank_next   = pick_idx;
          end
        end
        ST_ON: begin
          if (timer_reg == TW'(1)) begin
            state_next = ST_OFF;
            timer_next = TW'(OFFF);
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
        ST_OFF: begin
          if (timer_reg == TW'(1)) begin
            if (blinks_reg > BW'(1)) begin
              state_next  = ST_ON;
              timer_next  = TW'(ONF);
              blinks_next = blinks_reg - BW'(1);
            end else begin
              state_next = ST_GAP;
              timer_next = TW'(GAPF);
            end
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
        default: begin
          if (timer_reg == TW'(1)) begin
            if (pick_any) begin
              state_next  = ST_ON;
              timer_next  = TW'(ONF);
              blinks_next = BW'(pick_idx) + BW'(1);
              last_next   = pick_idx;
              bank_next   = pick_idx;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
      endcase
    end
  end

  assign led      = led_reg;
  assign busy     = busy_reg;
  assign cur_bank = bank_reg;

endmodule

// File: tb/tb_jtsdram_ledcode.sv
// Frame-level directed test of the LED blink-code multiplexer with short sim timings.
module tb_jtsdram_ledcode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       LVBL = 1'b0;
  logic [3:0] bad = 4'b0000;
  logic       led, busy;
  logic [2:0] cur_bank;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtsdram_ledcode #(
    .BANKS(4), .ONF(2), .OFFF(2), .GAPF(4), .TW(6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .LVBL     (LVBL),
    .bad      (bad),
    .led      (led),
    .busy     (busy),
    .cur_bank (cur_bank)
  );

  typedef struct {
    logic [3:0] bad;
    logic       led;
    logic       busy;
    logic [2:0] bank;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One frame: LVBL rises, stays high 8 clk, low 8 clk. Ends on a negedge.
  task automatic frame();
    @(negedge clk) LVBL = 1'b1;
    repeat (8) @(negedge clk);
    LVBL = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic add(input logic [3:0] b, input logic l, input logic bs, input logic [2:0] k);
    vec_t v;
    v.bad = b; v.led = l; v.busy = bs; v.bank = k;
    vq.push_back(v);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      bad = vq[i].bad;
      frame();
      $display("%s frame %0d: bad=%b led=%0b busy=%0b bank=%0d", tag, i + 1, bad, led, busy, cur_bank);
      chk($sformatf("%s[%0d].led", tag, i + 1), 8'(led), 8'(vq[i].led));
      chk($sformatf("%s[%0d].busy", tag, i + 1), 8'(busy), 8'(vq[i].busy));
      if (vq[i].busy) chk($sformatf("%s[%0d].bank", tag, i + 1), 8'(cur_bank), 8'(vq[i].bank));
    end
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    logic [0:17] pat18;
    logic [0:29] pat30;

    // Reset state
    repeat (3) @(negedge clk);
    $display("reset: led=%0b busy=%0b bank=%0d", led, busy, cur_bank);
    chk("reset.led", 8'(led), 8'd0);
    chk("reset.busy", 8'(busy), 8'd0);
    chk("reset.bank", 8'(cur_bank), 8'd0);
    rst_n = 1'b1;

    // No errors: stays dark and idle for 20 ticks
    for (int i = 0; i < 20; i++) add(4'b0000, 1'b0, 1'b0, 3'd0);
    run_table("idle");

    // Single bank 2: three blinks then gap, repeating every 16 ticks
    pat18 = 18'b110011001100000011;
    for (int i = 0; i < 18; i++) add(4'b0100, pat18[i], 1'b1, 3'd2);
    run_table("bank2");

    // Banks 0 and 3 alternate without passing through idle
    do_reset();
    pat30 = 30'b110000001100110011001100000011;
    for (int i = 0; i < 30; i++)
      add(4'b1001, pat30[i], 1'b1, (i < 8 || i >= 28) ? 3'd0 : 3'd3);
    run_table("rr");

    // bad cleared after the first blink: code completes, then idle
    do_reset();
    pat18 = 18'b110011001100000000;
    for (int i = 0; i < 18; i++)
      add((i < 2) ? 4'b0100 : 4'b0000, pat18[i], (i < 16) ? 1'b1 : 1'b0, 3'd2);
    run_table("clear");

    // Async reset during ON
    do_reset();
    bad = 4'b0100;
    frame();
    $display("pre-rst: led=%0b busy=%0b bank=%0d", led, busy, cur_bank);
    chk("prerst.led", 8'(led), 8'd1);
    chk("prerst.bank", 8'(cur_bank), 8'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async rst: led=%0b busy=%0b bank=%0d", led, busy, cur_bank);
    chk("arst.led", 8'(led), 8'd0);
    chk("arst.busy", 8'(busy), 8'd0);
    chk("arst.bank", 8'(cur_bank), 8'd0);
    @(negedge clk) rst_n = 1'b1;
    bad = 4'b0110;
    frame();
    $display("post-rst: led=%0b busy=%0b bank=%0d", led, busy, cur_bank);
    chk("postrst.led", 8'(led), 8'd1);
    chk("postrst.busy", 8'(busy), 8'd1);
    chk("postrst.bank", 8'(cur_bank), 8'd1);

    // LVBL stuck high mid-ON: one tick from the rise, then frozen
    @(negedge clk) LVBL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      repeat (10) @(negedge clk);
      $display("stuck %0d: led=%0b busy=%0b", k, led, busy);
      chk($sformatf("stuck[%0d].led", k), 8'(led), 8'd1);
      chk($sformatf("stuck[%0d].busy", k), 8'(busy), 8'd1);
    end
    LVBL = 1'b0;
    repeat (8) @(negedge clk);
    $display("stuck end: led=%0b busy=%0b", led, busy);
    chk("stuckend.led", 8'(led), 8'd1);
    // Bank 1 code continues: OFF, OFF, then second blink
    add(4'b0110, 1'b0, 1'b1, 3'd1);
    add(4'b0110, 1'b0, 1'b1, 3'd1);
    add(4'b0110, 1'b1, 1'b1, 3'd1);
    run_table("resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
